// File: rtl/fetch_decode_buffer_pkg.sv
// Shared decode definitions for the IF/ID buffer.
//   - instruction field bit positions (rdst, rsrc1, rsrc2)
//   - IMM_FLAG_BIT: when set, the word that follows is an immediate
//   - NOP_WORD: the all-zero bubble word
//   - state_t: S_INSTR expects an instruction, S_IMM expects the immediate
package fetch_decode_buffer_pkg;
  localparam int RDST_LSB     = 8;
  localparam int RSRC1_LSB    = 5;
  localparam int RSRC2_LSB    = 2;
  localparam int IMM_FLAG_BIT = 0;
  localparam logic [15:0] NOP_WORD = 16'h0000;

  typedef enum logic {
    S_INSTR = 1'b0,
    S_IMM   = 1'b1
  } state_t;
endpackage

// File: rtl/fetch_decode_buffer_if.sv
// Fetch -> decode bus for the IF/ID buffer.
//   fetch side : fetch_valid, instr_in, pc_in, stall, flush
//   decode side: valid_out, instr_out, imm_out, pc_out,
//                rdst_out, rsrc1_out, rsrc2_out, imm_pending
// slave  = the buffer itself, master = whoever drives fetch and watches decode.
interface fetch_decode_buffer_if #(
  parameter int WIDTH    = 16,
  parameter int PC_WIDTH = 32,
  parameter int N_REGS   = 8
);
  localparam int AW = $clog2(N_REGS);

  logic                fetch_valid;
  logic [WIDTH-1:0]    instr_in;
  logic [PC_WIDTH-1:0] pc_in;
  logic                stall;
  logic                flush;

  logic                valid_out;
  logic [WIDTH-1:0]    instr_out;
  logic [WIDTH-1:0]    imm_out;
  logic [PC_WIDTH-1:0] pc_out;
  logic [AW-1:0]       rdst_out;
  logic [AW-1:0]       rsrc1_out;
  logic [AW-1:0]       rsrc2_out;
  logic                imm_pending;

  modport slave (
    input  fetch_valid, instr_in, pc_in, stall, flush,
    output valid_out, instr_out, imm_out, pc_out,
           rdst_out, rsrc1_out, rsrc2_out, imm_pending
  );

  modport master (
    output fetch_valid, instr_in, pc_in, stall, flush,
    input  valid_out, instr_out, imm_out, pc_out,
           rdst_out, rsrc1_out, rsrc2_out, imm_pending
  );
endinterface

// File: rtl/fetch_decode_buffer.sv
// IF/ID pipeline register. Latches fetched words with their PC, pairs an
// instruction carrying IMM_FLAG with the immediate word that follows it into
// one decode packet (bubble while waiting), and supports stall and flush.
// Ports:
//   clk  - rising-edge clock
//   rst  - asynchronous active-high reset
//   bus  - fetch_decode_buffer_if.slave (fetch inputs, decode packet outputs)
// Register-address outputs are slices of the registered instruction, so the
// register file sampling on the falling edge sees settled addresses.
module fetch_decode_buffer
  import fetch_decode_buffer_pkg::*;
#(
  parameter int WIDTH    = 16,
  parameter int PC_WIDTH = 32,
  parameter int N_REGS   = 8
) (
  input  logic clk,
  input  logic rst,
  fetch_decode_buffer_if.slave bus
);
  localparam int AW = $clog2(N_REGS);

  state_t              state,      state_n;
  logic [WIDTH-1:0]    hold_instr, hold_instr_n;
  logic [PC_WIDTH-1:0] hold_pc,    hold_pc_n;
  logic                vld_q,      vld_n;
  logic [WIDTH-1:0]    instr_q,    instr_n;
  logic [WIDTH-1:0]    imm_q,      imm_n;
  logic [PC_WIDTH-1:0] pc_q,       pc_n;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_INSTR;
      hold_instr <= '0;
      hold_pc    <= '0;
      vld_q      <= 1'b0;
      instr_q    <= '0;
      imm_q      <= '0;
      pc_q       <= '0;
    end else begin
      state      <= state_n;
      hold_instr <= hold_instr_n;
      hold_pc    <= hold_pc_n;
      vld_q      <= vld_n;
      instr_q    <= instr_n;
      imm_q      <= imm_n;
      pc_q       <= pc_n;
    end
  end

  always_comb begin
    // hold everything by default; this is exactly the stall behaviour
    state_n      = state;
    hold_instr_n = hold_instr;
    hold_pc_n    = hold_pc;
    vld_n        = vld_q;
    instr_n      = instr_q;
    imm_n        = imm_q;
    pc_n         = pc_q;
    if (bus.flush) begin
      state_n      = S_INSTR;
      hold_instr_n = '0;
      hold_pc_n    = '0;
      vld_n        = 1'b0;
      instr_n      = WIDTH'(NOP_WORD);
      imm_n        = '0;
      pc_n         = '0;
    end else if (!bus.stall) begin
      // bubble unless a complete packet is formed this cycle
      vld_n   = 1'b0;
      instr_n = WIDTH'(NOP_WORD);
      imm_n   = '0;
      pc_n    = '0;
      case (state)
        S_INSTR: begin
          if (bus.fetch_valid) begin
            if (bus.instr_in[IMM_FLAG_BIT]) begin
              hold_instr_n = bus.instr_in;
              hold_pc_n    = bus.pc_in;
              state_n      = S_IMM;
            end else begin
              vld_n   = 1'b1;
              instr_n = bus.instr_in;
              pc_n    = bus.pc_in;
            end
          end
        end
        S_IMM: begin
          // the word here is pure data; its IMM_FLAG bit is not looked at
          if (bus.fetch_valid) begin
            vld_n   = 1'b1;
            instr_n = hold_instr;
            pc_n    = hold_pc;
            imm_n   = bus.instr_in;
            state_n = S_INSTR;
          end
        end
        default: state_n = S_INSTR;
      endcase
    end
  end

  assign bus.valid_out   = vld_q;
  assign bus.instr_out   = instr_q;
  assign bus.imm_out     = imm_q;
  assign bus.pc_out      = pc_q;
  assign bus.rdst_out    = instr_q[RDST_LSB  +: AW];
  assign bus.rsrc1_out   = instr_q[RSRC1_LSB +: AW];
  assign bus.rsrc2_out   = instr_q[RSRC2_LSB +: AW];
  assign bus.imm_pending = (state == S_IMM);
endmodule

// File: tb/tb_fetch_decode_buffer.sv
module tb_fetch_decode_buffer;
  logic clk;
  logic rst;

  fetch_decode_buffer_if #(.WIDTH(16), .PC_WIDTH(32), .N_REGS(8)) bus ();

  fetch_decode_buffer #(.WIDTH(16), .PC_WIDTH(32), .N_REGS(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic        fv;
    logic [15:0] ins;
    logic [31:0] pc;
    logic        st;
    logic        fl;
    logic        ev;
    logic [15:0] ei;
    logic [15:0] em;
    logic [31:0] ep;
    logic [2:0]  ed;
    logic [2:0]  e1;
    logic [2:0]  e2;
    logic        epd;
  } vec_t;

  localparam int NV = 20;
  vec_t v [NV];

  function automatic vec_t mk(logic fv, logic [15:0] ins, logic [31:0] pc,
                              logic st, logic fl, logic ev, logic [15:0] ei,
                              logic [15:0] em, logic [31:0] ep, logic [2:0] ed,
                              logic [2:0] e1, logic [2:0] e2, logic epd);
    vec_t r;
    r.fv = fv; r.ins = ins; r.pc = pc; r.st = st; r.fl = fl;
    r.ev = ev; r.ei = ei; r.em = em; r.ep = ep;
    r.ed = ed; r.e1 = e1; r.e2 = e2; r.epd = epd;
    return r;
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic drive(logic fv, logic [15:0] ins, logic [31:0] pc, logic st, logic fl);
    @(negedge clk);
    bus.fetch_valid = fv;
    bus.instr_in    = ins;
    bus.pc_in       = pc;
    bus.stall       = st;
    bus.flush       = fl;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_zero(string tag);
    chk({tag, " valid"}, 32'(bus.valid_out),   32'd0);
    chk({tag, " instr"}, 32'(bus.instr_out),   32'd0);
    chk({tag, " imm"},   32'(bus.imm_out),     32'd0);
    chk({tag, " pc"},    bus.pc_out,           32'd0);
    chk({tag, " rdst"},  32'(bus.rdst_out),    32'd0);
    chk({tag, " rsrc1"}, 32'(bus.rsrc1_out),   32'd0);
    chk({tag, " rsrc2"}, 32'(bus.rsrc2_out),   32'd0);
    chk({tag, " pend"},  32'(bus.imm_pending), 32'd0);
  endtask

  initial begin
    // row: fv ins pc st fl | ev instr imm pc rdst rs1 rs2 pend
    v[0]  = mk(1, 16'h4A94, 32'h10, 0, 0, 1, 16'h4A94, 16'h0,    32'h10, 3'd2, 3'd4, 3'd5, 0);
    v[1]  = mk(1, 16'h6821, 32'h20, 0, 0, 0, 16'h0,    16'h0,    32'h0,  3'd0, 3'd0, 3'd0, 1);
    v[2]  = mk(1, 16'hBEEF, 32'h22, 0, 0, 1, 16'h6821, 16'hBEEF, 32'h20, 3'd0, 3'd1, 3'd0, 0);
    v[3]  = mk(1, 16'h6821, 32'h30, 0, 0, 0, 16'h0,    16'h0,    32'h0,  3'd0, 3'd0, 3'd0, 1);
    v[4]  = mk(0, 16'h0000, 32'h0,  0, 0, 0, 16'h0,    16'h0,    32'h0,  3'd0, 3'd0, 3'd0, 1);
    v[5]  = mk(0, 16'h0000, 32'h0,  0, 0, 0, 16'h0,    16'h0,    32'h0,  3'd0, 3'd0, 3'd0, 1);
    v[6]  = mk(0, 16'h0000, 32'h0,  0, 0, 0, 16'h0,    16'h0,    32'h0,  3'd0, 3'd0, 3'd0, 1);
    v[7]  = mk(1, 16'h1234, 32'h32, 0, 0, 1, 16'h6821, 16'h1234, 32'h30, 3'd0, 3'd1, 3'd0, 0);
    v[8]  = mk(1, 16'h4A94, 32'h40, 0, 0, 1, 16'h4A94, 16'h0,    32'h40, 3'd2, 3'd4, 3'd5, 0);
    v[9]  = mk(1, 16'h1111, 32'h44, 1, 0, 1, 16'h4A94, 16'h0,    32'h40, 3'd2, 3'd4, 3'd5, 0);
    v[10] = mk(1, 16'h1111, 32'h44, 1, 0, 1, 16'h4A94, 16'h0,    32'h40, 3'd2, 3'd4, 3'd5, 0);
    v[11] = mk(1, 16'h2468, 32'h46, 0, 0, 1, 16'h2468, 16'h0,    32'h46, 3'd4, 3'd3, 3'd2, 0);
    v[12] = mk(1, 16'h6821, 32'h50, 0, 0, 0, 16'h0,    16'h0,    32'h0,  3'd0, 3'd0, 3'd0, 1);
    v[13] = mk(1, 16'hBEEF, 32'h52, 1, 0, 0, 16'h0,    16'h0,    32'h0,  3'd0, 3'd0, 3'd0, 1);
    v[14] = mk(1, 16'hBEEF, 32'h52, 1, 1, 0, 16'h0,    16'h0,    32'h0,  3'd0, 3'd0, 3'd0, 0);
    v[15] = mk(1, 16'hBEEF, 32'h54, 0, 0, 0, 16'h0,    16'h0,    32'h0,  3'd0, 3'd0, 3'd0, 1);
    v[16] = mk(1, 16'h0000, 32'h56, 0, 0, 1, 16'hBEEF, 16'h0,    32'h54, 3'd6, 3'd7, 3'd3, 0);
    v[17] = mk(0, 16'h0000, 32'h0,  0, 0, 0, 16'h0,    16'h0,    32'h0,  3'd0, 3'd0, 3'd0, 0);
    v[18] = mk(1, 16'h4A94, 32'h60, 0, 0, 1, 16'h4A94, 16'h0,    32'h60, 3'd2, 3'd4, 3'd5, 0);
    v[19] = mk(1, 16'h4A94, 32'h62, 0, 1, 0, 16'h0,    16'h0,    32'h0,  3'd0, 3'd0, 3'd0, 0);

    bus.fetch_valid = 1'b0;
    bus.instr_in    = '0;
    bus.pc_in       = '0;
    bus.stall       = 1'b0;
    bus.flush       = 1'b0;
    rst = 1'b1;
    #1;
    chk_zero("por");
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < NV; i++) begin
      string t;
      drive(v[i].fv, v[i].ins, v[i].pc, v[i].st, v[i].fl);
      t = $sformatf("row%0d", i);
      chk({t, " valid"}, 32'(bus.valid_out),   32'(v[i].ev));
      chk({t, " instr"}, 32'(bus.instr_out),   32'(v[i].ei));
      chk({t, " imm"},   32'(bus.imm_out),     32'(v[i].em));
      chk({t, " rdst"},  32'(bus.rdst_out),    32'(v[i].ed));
      chk({t, " rsrc1"}, 32'(bus.rsrc1_out),   32'(v[i].e1));
      chk({t, " rsrc2"}, 32'(bus.rsrc2_out),   32'(v[i].e2));
      chk({t, " pend"},  32'(bus.imm_pending), 32'(v[i].epd));
      if (v[i].ev) chk({t, " pc"}, bus.pc_out, v[i].ep);
    end

    // async reset while a valid packet is on the outputs, no clock edge
    drive(1, 16'h4A94, 32'h70, 0, 0);
    chk("pre-rst valid", 32'(bus.valid_out), 32'd1);
    @(negedge clk);
    bus.fetch_valid = 1'b0;
    #1 rst = 1'b1;
    #1 chk_zero("async-rst");
    #1 rst = 1'b0;

    // reset in the middle of a two-word instruction drops the held word
    drive(1, 16'h6821, 32'h80, 0, 0);
    chk("mid-imm pend", 32'(bus.imm_pending), 32'd1);
    @(negedge clk);
    bus.fetch_valid = 1'b0;
    #1 rst = 1'b1;
    #1 chk_zero("rst-in-imm");
    #1 rst = 1'b0;
    drive(1, 16'h2468, 32'h84, 0, 0);
    chk("post-rst valid", 32'(bus.valid_out), 32'd1);
    chk("post-rst instr", 32'(bus.instr_out), 32'h2468);
    chk("post-rst imm",   32'(bus.imm_out),   32'h0);
    chk("post-rst pc",    bus.pc_out,         32'h84);
    chk("post-rst pend",  32'(bus.imm_pending), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
